module_rgb_pwm_sequencer: RTL and testbench



---
 rtl/rgb_pkg.sv | 45 ++++
 rtl/module_rgb_pwm_sequencer_if.sv | 22 ++
 rtl/module_rgb_pwm_sequencer_timebase.sv | 46 ++++
 rtl/module_rgb_pwm_sequencer.sv | 94 +++++++++
 tb/tb_module_rgb_pwm_sequencer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_pkg.sv
// Shared types and constants for the multi-LED RGB PWM sequencer.
package rgb_pkg;

    localparam int unsigned DUTY_W = 16;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        SOLID = 2'd1,
        BLINK = 2'd2,
        RSVD  = 2'd3
    } led_mode_t;

    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    localparam int unsigned R_IDX = 2;
    localparam int unsigned G_IDX = 1;
    localparam int unsigned B_IDX = 0;

    // duty is held at the widest supported PWM width; narrower counters are zero-extended
    typedef struct packed {
        logic [2:0]        color;
        logic [DUTY_W-1:0] duty;
        led_mode_t         mode;
    } led_cfg_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } cmd_state_t;

    // Unregistered {R,G,B} level for one LED at the given PWM count and blink phase
    function automatic logic [2:0] led_raw(input led_cfg_t cfg,
                                           input logic [DUTY_W-1:0] cnt,
                                           input logic blink_on);
        logic en;
        en = (cfg.mode == SOLID) || ((cfg.mode == BLINK) && blink_on);
        return (en && (cnt < cfg.duty)) ? cfg.color : 3'b000;
    endfunction

endpackage

// File: rtl/module_rgb_pwm_sequencer_if.sv
// Command port of the RGB PWM sequencer: one valid/ready transfer per LED update.
interface module_rgb_pwm_sequencer_if #(
    parameter int unsigned LED_W    = 1,
    parameter int unsigned PWM_BITS = 8
);
    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic [LED_W-1:0]    cmd_led_i;
    logic [2:0]          cmd_color_i;
    logic [PWM_BITS-1:0] cmd_duty_i;
    logic [1:0]          cmd_mode_i;

    modport master (
        output cmd_valid_i, cmd_led_i, cmd_color_i, cmd_duty_i, cmd_mode_i,
        input  cmd_ready_o
    );

    modport slave (
        input  cmd_valid_i, cmd_led_i, cmd_color_i, cmd_duty_i, cmd_mode_i,
        output cmd_ready_o
    );
endinterface

// File: rtl/module_rgb_pwm_sequencer_timebase.sv
// Prescaler, PWM counter, frame counter and global blink phase.
module module_pwm_timebase #(
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned PRESC        = 40,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                frame_tick_c,
    output logic                blink_on
);
    localparam int unsigned PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PRESC_W-1:0] presc_q;
    logic [FRAME_W-1:0] frame_q;
    logic               tick_c;

    assign tick_c       = (presc_q == PRESC_W'(PRESC - 1));
    assign frame_tick_c = tick_c && (pwm_cnt == '1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q  <= '0;
            pwm_cnt  <= '0;
            frame_q  <= '0;
            blink_on <= 1'b1;
        end else begin
            presc_q <= tick_c ? '0 : presc_q + PRESC_W'(1);
            if (tick_c) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end
            // blink phase flips every BLINK_FRAMES boundaries
            if (frame_tick_c) begin
                if (frame_q == FRAME_W'(BLINK_FRAMES - 1)) begin
                    frame_q  <= '0;
                    blink_on <= ~blink_on;
                end else begin
                    frame_q <= frame_q + FRAME_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/module_rgb_pwm_sequencer.sv
// Multi-LED RGB PWM controller; commands are shadowed and applied on frame boundaries.
module module_rgb_pwm_sequencer
    import rgb_pkg::*;
#(
    parameter int unsigned N_LEDS       = 2,
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned PRESC        = 40,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter bit          ACTIVE_LOW   = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    module_rgb_pwm_sequencer_if.slave  cmd,
    output logic [3*N_LEDS-1:0]        rgb_o,
    output logic                       frame_o
);
    localparam int unsigned LED_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam logic [3*N_LEDS-1:0] RGB_INV = {(3*N_LEDS){ACTIVE_LOW}};

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                frame_tick_c;
    logic                blink_on;

    cmd_state_t          state_q;
    logic [LED_W-1:0]    shadow_led_q;
    led_cfg_t            shadow_cfg_q;
    led_cfg_t            cfg_q [N_LEDS];
    logic [3*N_LEDS-1:0] raw_c;

    module_pwm_timebase #(
        .PWM_BITS     (PWM_BITS),
        .PRESC        (PRESC),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_timebase (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pwm_cnt      (pwm_cnt),
        .frame_tick_c (frame_tick_c),
        .blink_on     (blink_on)
    );

    // Per-LED channel levels before the output register
    always_comb begin
        raw_c = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            raw_c[3*i +: 3] = led_raw(cfg_q[i], DUTY_W'(pwm_cnt), blink_on);
        end
    end

    // Command FSM: IDLE accepts into the shadow, PEND waits for the next frame boundary
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            cmd.cmd_ready_o <= 1'b1;
            shadow_led_q    <= '0;
            shadow_cfg_q    <= '0;
            for (int i = 0; i < N_LEDS; i++) begin
                cfg_q[i] <= '0;
            end
            rgb_o   <= RGB_INV;
            frame_o <= 1'b0;
        end else begin
            rgb_o   <= raw_c ^ RGB_INV;
            frame_o <= frame_tick_c;
            case (state_q)
                ST_IDLE: begin
                    if (cmd.cmd_valid_i) begin
                        shadow_led_q       <= cmd.cmd_led_i;
                        shadow_cfg_q.color <= cmd.cmd_color_i;
                        shadow_cfg_q.duty  <= DUTY_W'(cmd.cmd_duty_i);
                        shadow_cfg_q.mode  <= led_mode_t'(cmd.cmd_mode_i);
                        state_q            <= ST_PEND;
                        cmd.cmd_ready_o    <= 1'b0;
                    end
                end
                ST_PEND: begin
                    // out-of-range LED indices are consumed without effect
                    if (frame_tick_c) begin
                        if (32'(shadow_led_q) < N_LEDS) begin
                            cfg_q[shadow_led_q] <= shadow_cfg_q;
                        end
                        state_q         <= ST_IDLE;
                        cmd.cmd_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state_q         <= ST_IDLE;
                    cmd.cmd_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_module_rgb_pwm_sequencer.sv
// Directed bench: 16-cycle frames, patterns checked against a small per-LED model.
module tb_module_rgb_pwm_sequencer;
    import rgb_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    module_rgb_pwm_sequencer_if #(.LED_W(1), .PWM_BITS(4)) if_a ();
    module_rgb_pwm_sequencer_if #(.LED_W(2), .PWM_BITS(4)) if_b ();
    module_rgb_pwm_sequencer_if #(.LED_W(1), .PWM_BITS(4)) if_c ();

    logic [5:0] rgb_a, rgb_c;
    logic [8:0] rgb_b;
    logic       frame_a, frame_b, frame_c;

    module_rgb_pwm_sequencer #(.N_LEDS(2), .PWM_BITS(4), .PRESC(1), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b0))
        dut_a (.clk_i(clk_i), .rst_i(rst_i), .cmd(if_a), .rgb_o(rgb_a), .frame_o(frame_a));
    module_rgb_pwm_sequencer #(.N_LEDS(3), .PWM_BITS(4), .PRESC(1), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b0))
        dut_b (.clk_i(clk_i), .rst_i(rst_i), .cmd(if_b), .rgb_o(rgb_b), .frame_o(frame_b));
    module_rgb_pwm_sequencer #(.N_LEDS(2), .PWM_BITS(4), .PRESC(1), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b1))
        dut_c (.clk_i(clk_i), .rst_i(rst_i), .cmd(if_c), .rgb_o(rgb_c), .frame_o(frame_c));

    int n_checks = 0;
    int n_fail   = 0;
    int nfr      = 0;

    logic [2:0] m_col  [2];
    int         m_duty [2];
    int         m_mode [2];

    // Frame pulses of instance A since reset; the pulse in the current cycle is not yet counted
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) nfr <= 0;
        else if (frame_a) nfr <= nfr + 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input int led, input logic [2:0] col,
                         input logic [3:0] duty, input logic [1:0] mode);
        case (sel)
            0: begin if_a.cmd_valid_i = v; if_a.cmd_led_i = 1'(led); if_a.cmd_color_i = col;
                     if_a.cmd_duty_i = duty; if_a.cmd_mode_i = mode; end
            1: begin if_b.cmd_valid_i = v; if_b.cmd_led_i = 2'(led); if_b.cmd_color_i = col;
                     if_b.cmd_duty_i = duty; if_b.cmd_mode_i = mode; end
            default: begin if_c.cmd_valid_i = v; if_c.cmd_led_i = 1'(led); if_c.cmd_color_i = col;
                     if_c.cmd_duty_i = duty; if_c.cmd_mode_i = mode; end
        endcase
    endtask

    function automatic logic ready_of(input int sel);
        case (sel)
            0:       return if_a.cmd_ready_o;
            1:       return if_b.cmd_ready_o;
            default: return if_c.cmd_ready_o;
        endcase
    endfunction

    task automatic send_cmd(input int sel, input int led, input logic [2:0] col,
                            input logic [3:0] duty, input logic [1:0] mode);
        @(negedge clk_i);
        drive(sel, 1'b1, led, col, duty, mode);
        for (int i = 0; i < 40 && !ready_of(sel); i++) @(negedge clk_i);
        check("send_ready", 128'(ready_of(sel)), 128'(1));
        @(posedge clk_i);
        #1 drive(sel, 1'b0, 0, 3'b000, 4'd0, 2'd0);
    endtask

    // Returns at the first cycle with ready high again, i.e. the cycle after apply
    task automatic wait_apply(input int sel);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (ready_of(sel)) break;
        end
        check("apply_ready", 128'(ready_of(sel)), 128'(1));
    endtask

    task automatic wait_frame();
        @(negedge clk_i);
        for (int i = 0; i < 40 && !frame_a; i++) @(negedge clk_i);
        check("wait_frame", 128'(frame_a), 128'(1));
    endtask

    task automatic first_frame(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!frame_a && n < 40);
        check(tag, 128'(n), 128'(16));
    endtask

    function automatic logic [95:0] exp_frame(input int k);
        logic [95:0] e;
        bit          blink;
        e     = '0;
        blink = ((k / 2) % 2) == 0;
        for (int off = 1; off < 16; off++) begin
            for (int led = 0; led < 2; led++) begin
                if (off <= m_duty[led] && (m_mode[led] == 1 || (m_mode[led] == 2 && blink)))
                    e[off*6 + led*3 +: 3] = m_col[led];
            end
        end
        return e;
    endfunction

    // Captures 16 samples of instance A starting at the current frame_o cycle
    task automatic check_frame(input string tag);
        logic [95:0] cap;
        int          k;
        k = nfr + 1;
        check({tag, "_align"}, 128'(frame_a), 128'(1));
        for (int off = 0; off < 16; off++) begin
            if (off > 0) @(negedge clk_i);
            cap[off*6 +: 6] = rgb_a;
        end
        check(tag, 128'(cap), 128'(exp_frame(k)));
    endtask

    task automatic set_model(input int led, input logic [2:0] col, input int duty, input int mode);
        m_col[led]  = col;
        m_duty[led] = duty;
        m_mode[led] = mode;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rgb_a"}, 128'(rgb_a), 128'(0));
        check({tag, "_rgb_b"}, 128'(rgb_b), 128'(0));
        check({tag, "_rgb_c"}, 128'(rgb_c), 128'(6'h3F));
        check({tag, "_rdy_a"}, 128'(if_a.cmd_ready_o), 128'(1));
        check({tag, "_frame"}, 128'(frame_a), 128'(0));
    endtask

    initial begin
        logic [8:0] acc_b;
        logic [5:0] and_c;
        int         low_c;

        for (int s = 0; s < 3; s++) drive(s, 1'b0, 0, 3'b000, 4'd0, 2'd0);
        for (int l = 0; l < 2; l++) set_model(l, 3'b000, 0, 0);
        repeat (3) @(negedge clk_i);
        check_reset("por");
        check("por_rdy_b", 128'(if_b.cmd_ready_o), 128'(1));
        rst_i = 1'b0;
        first_frame("por_first_frame");

        // SOLID magenta at duty 4 on LED0, two consecutive frames
        send_cmd(0, 0, MAGENTA, 4'd4, 2'(SOLID));
        wait_apply(0);
        set_model(0, MAGENTA, 4, 1);
        check_frame("solid_f0");
        @(negedge clk_i);
        check_frame("solid_f1");

        // Duty extremes on LED1
        send_cmd(0, 1, WHITE, 4'd0, 2'(SOLID));
        wait_apply(0);
        set_model(1, WHITE, 0, 1);
        check_frame("duty0");
        send_cmd(0, 1, WHITE, 4'd15, 2'(SOLID));
        wait_apply(0);
        set_model(1, WHITE, 15, 1);
        check_frame("duty15");

        // BLINK yellow on LED0 across four frames
        send_cmd(0, 0, YELLOW, 4'd15, 2'(BLINK));
        wait_apply(0);
        set_model(0, YELLOW, 15, 2);
        check_frame("blink_f0");
        for (int f = 1; f < 4; f++) begin
            @(negedge clk_i);
            check_frame($sformatf("blink_f%0d", f));
        end

        // Accept on a boundary edge, second command held valid while busy
        wait_frame();
        repeat (15) @(negedge clk_i);
        drive(0, 1'b1, 0, BLUE, 4'd8, 2'(SOLID));
        check("hs_ready_pre", 128'(if_a.cmd_ready_o), 128'(1));
        @(negedge clk_i);
        check("hs_ready_drop", 128'(if_a.cmd_ready_o), 128'(0));
        check("hs_boundary", 128'(frame_a), 128'(1));
        drive(0, 1'b1, 1, GREEN, 4'd3, 2'(SOLID));
        repeat (15) @(negedge clk_i);
        check("hs_ready_busy", 128'(if_a.cmd_ready_o), 128'(0));
        @(negedge clk_i);
        check("hs_ready_back", 128'(if_a.cmd_ready_o), 128'(1));
        check("hs_apply_frame", 128'(frame_a), 128'(1));
        set_model(0, BLUE, 8, 1);
        @(negedge clk_i);
        check("hs_second_acc", 128'(if_a.cmd_ready_o), 128'(0));
        check("hs_rgb_first", 128'(rgb_a), 128'(6'b111_001));
        drive(0, 1'b0, 0, 3'b000, 4'd0, 2'd0);
        wait_apply(0);
        set_model(1, GREEN, 3, 1);
        check_frame("hs_led1_only");

        // Instance B: valid index lights LED2, invalid index 3 changes nothing
        send_cmd(1, 2, WHITE, 4'd15, 2'(SOLID));
        wait_apply(1);
        acc_b = '0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk_i);
            acc_b |= rgb_b;
        end
        check("b_led2", 128'(acc_b), 128'(9'h1C0));
        send_cmd(1, 3, WHITE, 4'd15, 2'(SOLID));
        wait_apply(1);
        acc_b = '0;
        for (int i = 0; i < 16; i++) begin
            if (i == 2) check("b_inv_sample", 128'(rgb_b), 128'(9'h1C0));
            if (i > 0) @(negedge clk_i);
            acc_b |= rgb_b;
        end
        check("b_inv_or", 128'(acc_b), 128'(9'h1C0));

        // Instance C: active-low outputs, red at duty 4
        send_cmd(2, 0, RED, 4'd4, 2'(SOLID));
        wait_apply(2);
        and_c = '1;
        low_c = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk_i);
            if (i == 1) check("c_sample", 128'(rgb_c), 128'(6'b111_011));
            if (!rgb_c[R_IDX]) low_c++;
            and_c &= rgb_c | 6'b000_100;
        end
        check("c_low_cycles", 128'(low_c), 128'(4));
        check("c_others_high", 128'(and_c), 128'(6'h3F));

        // Asynchronous reset mid-frame with a command pending
        wait_frame();
        @(negedge clk_i);
        check("pre_rst_rgb", 128'(rgb_a), 128'(6'b010_001));
        drive(0, 1'b1, 0, WHITE, 4'd15, 2'(SOLID));
        @(posedge clk_i);
        #1 drive(0, 1'b0, 0, 3'b000, 4'd0, 2'd0);
        check("pending_busy", 128'(if_a.cmd_ready_o), 128'(0));
        #2 rst_i = 1'b1;
        #1 check_reset("mid_rst");
        for (int l = 0; l < 2; l++) set_model(l, 3'b000, 0, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        first_frame("rst_first_frame");
        check_frame("rst_dropped");
        check("rst_ready", 128'(if_a.cmd_ready_o), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
